// File: rtl/mem_arb_pkg.sv
// Shared types and block geometry for the I/D memory arbiter.
// Word-index and counter widths derive from BLOCK_WORDS.
package mem_arb_pkg;

  localparam int BLOCK_WORDS = 8;
  localparam int WORD_IDX_W  = $clog2(BLOCK_WORDS);
  // One bit wider than the index so "all words issued" is representable.
  localparam int CNT_W       = WORD_IDX_W + 1;
  // Lowest block-address bit: word index bits plus the byte bit.
  localparam int BLOCK_OFF   = WORD_IDX_W + 1;
  localparam int DATA_W      = 16;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    WRITE
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_arbiter_arb_rr2.sv
// Combinational two-way round-robin picker; the last-grant state lives in the parent.
// On a tie the requester that was not granted last wins.
module arb_rr2
  import mem_arb_pkg::*;
(
  input  logic   i_req,
  input  logic   d_req,
  input  owner_t last_grant,
  output logic   grant,
  output owner_t pick
);

  always_comb begin
    grant = i_req | d_req;
    pick  = OWN_I;
    if (i_req && d_req) begin
      if (last_grant == OWN_I) begin
        pick = OWN_D;
      end else begin
        pick = OWN_I;
      end
    end else if (d_req) begin
      pick = OWN_D;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one pipelined memory between the I- and D-cache miss handlers:
// 8-word block fills for either side, single-word write-through for D.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 16,
  parameter int MEM_LATENCY = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  i_valid,
  output logic [DATA_W-1:0]     i_data,
  output logic [WORD_IDX_W-1:0] i_word,
  output logic                  i_done,
  input  logic                  d_req,
  input  logic                  d_wr,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_W-1:0]     d_wdata,
  output logic                  d_valid,
  output logic [DATA_W-1:0]     d_data,
  output logic [WORD_IDX_W-1:0] d_word,
  output logic                  d_done,
  output logic                  mem_en,
  output logic                  mem_wr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic                  mem_valid,
  output logic                  busy
);

  state_t                  state_reg, state_next;
  owner_t                  owner_reg, owner_next;
  owner_t                  last_grant_reg, last_grant_next;
  logic [CNT_W-1:0]        issue_reg, issue_next;
  logic [CNT_W-1:0]        recv_reg, recv_next;
  // Word address: block base for fills, full word address for writes.
  logic [ADDR_WIDTH-1:1]   base_reg, base_next;
  logic [DATA_W-1:0]       wdata_reg, wdata_next;

  logic   grant;
  owner_t pick;

  // Read latency is absorbed by the recv counter, so it never enters the logic.
  logic unused_bits;
  assign unused_bits = ^{i_addr[BLOCK_OFF-1:0], d_addr[0], MEM_LATENCY};

  arb_rr2 u_arb (
    .i_req      (i_req),
    .d_req      (d_req),
    .last_grant (last_grant_reg),
    .grant      (grant),
    .pick       (pick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      owner_reg      <= OWN_I;
      last_grant_reg <= OWN_I;
      issue_reg      <= '0;
      recv_reg       <= '0;
      base_reg       <= '0;
      wdata_reg      <= '0;
    end else begin
      state_reg      <= state_next;
      owner_reg      <= owner_next;
      last_grant_reg <= last_grant_next;
      issue_reg      <= issue_next;
      recv_reg       <= recv_next;
      base_reg       <= base_next;
      wdata_reg      <= wdata_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    owner_next      = owner_reg;
    last_grant_next = last_grant_reg;
    issue_next      = issue_reg;
    recv_next       = recv_reg;
    base_next       = base_reg;
    wdata_next      = wdata_reg;
    unique case (state_reg)
      IDLE: begin
        if (grant) begin
          owner_next      = pick;
          last_grant_next = pick;
          issue_next      = '0;
          recv_next       = '0;
          state_next      = FILL;
          if (pick == OWN_D) begin
            if (d_wr) begin
              state_next = WRITE;
              base_next  = d_addr[ADDR_WIDTH-1:1];
              wdata_next = d_wdata;
            end else begin
              base_next = {d_addr[ADDR_WIDTH-1:BLOCK_OFF], {(BLOCK_OFF-1){1'b0}}};
            end
          end else begin
            base_next = {i_addr[ADDR_WIDTH-1:BLOCK_OFF], {(BLOCK_OFF-1){1'b0}}};
          end
        end
      end
      FILL: begin
        if (issue_reg < CNT_W'(BLOCK_WORDS)) begin
          issue_next = issue_reg + CNT_W'(1);
        end
        if (mem_valid) begin
          recv_next = recv_reg + CNT_W'(1);
          if (recv_reg == CNT_W'(BLOCK_WORDS - 1)) begin
            state_next = IDLE;
          end
        end
      end
      WRITE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  logic in_fill, in_write, issuing, fill_ret, fill_last;
  assign in_fill   = (state_reg == FILL);
  assign in_write  = (state_reg == WRITE);
  assign issuing   = in_fill && (issue_reg < CNT_W'(BLOCK_WORDS));
  assign fill_ret  = in_fill && mem_valid;
  assign fill_last = fill_ret && (recv_reg == CNT_W'(BLOCK_WORDS - 1));

  assign busy      = (state_reg != IDLE);
  assign mem_en    = issuing || in_write;
  assign mem_wr    = in_write;
  assign mem_wdata = in_write ? wdata_reg : '0;

  always_comb begin
    mem_addr = '0;
    if (issuing) begin
      mem_addr = {base_reg[ADDR_WIDTH-1:BLOCK_OFF], issue_reg[WORD_IDX_W-1:0], 1'b0};
    end else if (in_write) begin
      mem_addr = {base_reg, 1'b0};
    end
  end

  // Per-side return steering; the non-owner side stays all-zero.
  logic [1:0]            side_valid, side_done;
  logic [DATA_W-1:0]     side_data [2];
  logic [WORD_IDX_W-1:0] side_word [2];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_side
      localparam owner_t SIDE = (gi == 0) ? OWN_I : OWN_D;
      logic owns;
      assign owns           = (owner_reg == SIDE);
      assign side_valid[gi] = owns && fill_ret;
      assign side_data[gi]  = side_valid[gi] ? mem_rdata : '0;
      assign side_word[gi]  = side_valid[gi] ? recv_reg[WORD_IDX_W-1:0] : '0;
      assign side_done[gi]  = owns && (fill_last || in_write);
    end
  endgenerate

  assign i_valid = side_valid[0];
  assign i_data  = side_data[0];
  assign i_word  = side_word[0];
  assign i_done  = side_done[0];
  assign d_valid = side_valid[1];
  assign d_data  = side_data[1];
  assign d_word  = side_word[1];
  assign d_done  = side_done[1];

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a 4-cycle pipelined memory model.
// Each scenario task drives stimulus and checks cycle-exact expectations.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_req = 1'b0;
  logic [15:0] i_addr = 16'h0;
  logic        i_valid, i_done;
  logic [15:0] i_data;
  logic [2:0]  i_word;
  logic        d_req = 1'b0;
  logic        d_wr = 1'b0;
  logic [15:0] d_addr = 16'h0;
  logic [15:0] d_wdata = 16'h0;
  logic        d_valid, d_done;
  logic [15:0] d_data;
  logic [2:0]  d_word;
  logic        mem_en, mem_wr, busy;
  logic [15:0] mem_addr, mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_valid;

  int n_checks = 0;
  int n_fail = 0;

  logic        spur_valid = 1'b0;
  logic [15:0] spur_data = 16'h0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_WIDTH(16), .MEM_LATENCY(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_valid(i_valid), .i_data(i_data),
    .i_word(i_word), .i_done(i_done),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_valid(d_valid), .d_data(d_data), .d_word(d_word), .d_done(d_done),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_valid(mem_valid), .busy(busy)
  );

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return a ^ 16'h5A5A;
  endfunction

  // Memory: read sampled at an edge returns four cycles after its issue cycle.
  logic [3:0]  pipe_v;
  logic [15:0] pipe_d [4];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_v <= 4'h0;
      for (int k = 0; k < 4; k++) pipe_d[k] <= 16'h0;
    end else begin
      pipe_v    <= {pipe_v[2:0], mem_en && !mem_wr};
      pipe_d[0] <= mem_word(mem_addr);
      for (int k = 1; k < 4; k++) pipe_d[k] <= pipe_d[k-1];
    end
  end
  assign mem_valid = pipe_v[3] | spur_valid;
  assign mem_rdata = spur_valid ? spur_data : (pipe_v[3] ? pipe_d[3] : 16'h0);

  logic [20:0] i_bus, d_bus;
  logic [76:0] all_out;
  assign i_bus   = {i_valid, i_data, i_word, i_done};
  assign d_bus   = {d_valid, d_data, d_word, d_done};
  assign all_out = {i_bus, d_bus, mem_en, mem_wr, mem_addr, mem_wdata, busy};

  always @(negedge clk) begin
    n_checks++;
    if ((mem_wr && (pipe_v != 4'h0)) || (i_valid && d_valid) || (i_done && d_done) ||
        (!i_valid && i_data != 16'h0) || (!d_valid && d_data != 16'h0)) begin
      n_fail++;
      $display("FAIL invariant t=%0t: mem_wr=%b inflight=%b i_v=%b d_v=%b i_data=%h d_data=%h",
               $time, mem_wr, pipe_v, i_valid, d_valid, i_data, d_data);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Called in the grant cycle (cycle 0); returns in cycle 13 with the owner req dropped.
  task automatic run_fill(input bit is_d, input logic [15:0] base);
    logic [20:0] exp_own;
    logic [15:0] exp_maddr;
    bit en, v;
    for (int c = 1; c <= 13; c++) begin
      @(posedge clk); #1;
      en = (c <= 8);
      v  = (c >= 5) && (c <= 12);
      exp_maddr = en ? base + 16'(2 * (c - 1)) : 16'h0;
      exp_own = v ? {1'b1, mem_word(base + 16'(2 * (c - 5))), 3'(c - 5), 1'(c == 12)} : 21'h0;
      n_checks++;
      if ({mem_en, mem_wr, mem_addr} !== {en, 1'b0, exp_maddr}) begin
        n_fail++;
        $display("FAIL fill_mem c=%0d: got en=%b wr=%b addr=%h, expected en=%b wr=0 addr=%h",
                 c, mem_en, mem_wr, mem_addr, en, exp_maddr);
      end
      n_checks++;
      if ((is_d ? d_bus : i_bus) !== exp_own) begin
        n_fail++;
        $display("FAIL fill_owner c=%0d: got %h expected %h", c, is_d ? d_bus : i_bus, exp_own);
      end
      n_checks++;
      if ((is_d ? i_bus : d_bus) !== 21'h0) begin
        n_fail++;
        $display("FAIL fill_other c=%0d: got %h expected 0", c, is_d ? i_bus : d_bus);
      end
      n_checks++;
      if (busy !== (c <= 12)) begin
        n_fail++;
        $display("FAIL fill_busy c=%0d: got %b expected %b", c, busy, (c <= 12));
      end
      if (c == 1) begin
        if (is_d) d_addr = 16'hFFFF; else i_addr = 16'hFFFF;
      end
      if (c == 13) begin
        if (is_d) d_req = 1'b0; else i_req = 1'b0;
      end
    end
    $display("fill %s base=%h complete", is_d ? "D" : "I", base);
  endtask

  // Called in the grant cycle with a D write request driven.
  task automatic run_write(input logic [15:0] addr, input logic [15:0] data);
    @(posedge clk); #1;
    d_addr  = 16'h0;
    d_wdata = 16'h0;
    #1;
    n_checks++;
    if ({mem_en, mem_wr, mem_addr, mem_wdata} !== {1'b1, 1'b1, addr, data}) begin
      n_fail++;
      $display("FAIL write_mem: got en=%b wr=%b addr=%h wdata=%h, expected 1 1 %h %h",
               mem_en, mem_wr, mem_addr, mem_wdata, addr, data);
    end
    n_checks++;
    if ({d_bus, i_bus, busy} !== {1'b0, 16'h0, 3'h0, 1'b1, 21'h0, 1'b1}) begin
      n_fail++;
      $display("FAIL write_done: got d=%h i=%h busy=%b, expected d=000001 i=0 busy=1",
               d_bus, i_bus, busy);
    end
    @(posedge clk); #1;
    n_checks++;
    if ({busy, mem_en, mem_wr, d_done} !== 4'b0000) begin
      n_fail++;
      $display("FAIL write_idle: got busy=%b en=%b wr=%b done=%b, expected 0000",
               busy, mem_en, mem_wr, d_done);
    end
    d_req = 1'b0;
    d_wr  = 1'b0;
    $display("write addr=%h data=%h complete", addr, data);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (all_out !== 77'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected 0", all_out);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (all_out !== 77'h0) begin
      n_fail++;
      $display("FAIL idle_outputs: got %h expected 0", all_out);
    end
    $display("reset checked");
  endtask

  task automatic test_i_fill();
    i_addr = 16'h1236;
    i_req  = 1'b1;
    run_fill(1'b0, 16'h1230);
  endtask

  task automatic test_d_write();
    d_wr    = 1'b1;
    d_addr  = 16'h4002;
    d_wdata = 16'hBEEF;
    d_req   = 1'b1;
    run_write(16'h4002, 16'hBEEF);
  endtask

  task automatic test_tie();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    i_addr = 16'h3456;
    d_addr = 16'h5678;
    d_wr   = 1'b0;
    i_req  = 1'b1;
    d_req  = 1'b1;
    run_fill(1'b1, 16'h5670);
    d_wr    = 1'b1;
    d_addr  = 16'h6004;
    d_wdata = 16'h1111;
    d_req   = 1'b1;
    run_fill(1'b0, 16'h3450);
    run_write(16'h6004, 16'h1111);
  endtask

  task automatic test_write_during_fill();
    i_addr = 16'h7894;
    i_req  = 1'b1;
    fork
      run_fill(1'b0, 16'h7890);
      begin
        repeat (3) @(posedge clk);
        #2;
        d_wr    = 1'b1;
        d_addr  = 16'h0A0C;
        d_wdata = 16'hC0DE;
        d_req   = 1'b1;
      end
    join
    run_write(16'h0A0C, 16'hC0DE);
  endtask

  task automatic test_reset_mid_fill();
    i_addr = 16'h2340;
    i_req  = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (all_out !== 77'h0) begin
      n_fail++;
      $display("FAIL reset_async: got %h expected 0", all_out);
    end
    i_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (all_out !== 77'h0) begin
      n_fail++;
      $display("FAIL reset_hold: got %h expected 0", all_out);
    end
    rst_n  = 1'b1;
    i_addr = 16'h2346;
    i_req  = 1'b1;
    run_fill(1'b0, 16'h2340);
  endtask

  task automatic test_spurious();
    spur_data  = 16'hFFFF;
    spur_valid = 1'b1;
    #1;
    n_checks++;
    if ({i_bus, d_bus, busy, mem_en} !== 44'h0) begin
      n_fail++;
      $display("FAIL spurious_now: got i=%h d=%h busy=%b en=%b expected 0", i_bus, d_bus, busy, mem_en);
    end
    @(posedge clk); #1;
    n_checks++;
    if ({i_bus, d_bus, busy, mem_en} !== 44'h0) begin
      n_fail++;
      $display("FAIL spurious_next: got i=%h d=%h busy=%b en=%b expected 0", i_bus, d_bus, busy, mem_en);
    end
    spur_valid = 1'b0;
    spur_data  = 16'h0;
    $display("spurious mem_valid in idle checked");
  endtask

  initial begin
    test_reset();
    test_i_fill();
    test_d_write();
    test_tie();
    test_write_during_fill();
    test_reset_mid_fill();
    test_spurious();
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
